// File: rtl/call_stack_if.sv
// Decoder-to-return-stack bundle: CALL/RET strobes and return address in,
// top-of-stack and status out.
interface call_stack_if #(
    parameter int ADDR_W = 16,
    parameter int PTR_W  = 4
);
    // Strobe semantics: StackPush/StackPop are single-cycle requests with no
    // ready; each one not masked by Stall is accepted at the next rising
    // edge. TopAddr and the status outputs are valid every cycle.
    logic              StackPush;
    logic              StackPop;
    logic              Stall;
    logic [ADDR_W-1:0] ReturnAddr;
    logic [ADDR_W-1:0] TopAddr;
    logic [PTR_W:0]    Depth;
    logic              Empty;
    logic              Full;
    logic              Overflow;
    logic              Underflow;

    modport master (
        output StackPush, StackPop, Stall, ReturnAddr,
        input  TopAddr, Depth, Empty, Full, Overflow, Underflow
    );

    modport slave (
        input  StackPush, StackPop, Stall, ReturnAddr,
        output TopAddr, Depth, Empty, Full, Overflow, Underflow
    );
endinterface

// File: rtl/call_stack.sv
// Return-address LIFO for the game processor: stores PC+1 on CALL and
// presents the top entry combinationally so RET can use it the same cycle.
module call_stack #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4
) (
    input  logic         clk,
    input  logic         rst,
    call_stack_if.slave  bus
);
    localparam logic [PTR_W:0] ONE      = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W:0]    depthQ;
    logic [PTR_W:0]    depthNext;
    logic              overflowQ;
    logic              underflowQ;

    logic              pushEff;
    logic              popEff;
    logic              isEmpty;
    logic              isFull;
    logic [PTR_W-1:0]  wrIdx;
    logic [PTR_W-1:0]  rdIdx;
    logic [PTR_W-1:0]  wrSel;
    logic              doWrite;
    logic              setOvf;
    logic              setUnf;

    assign pushEff = bus.StackPush & ~bus.Stall;
    assign popEff  = bus.StackPop  & ~bus.Stall;
    assign isEmpty = (depthQ == '0);
    assign isFull  = (depthQ == FULL_LVL);
    assign wrIdx   = depthQ[PTR_W-1:0];
    // At full depth the low bits are zero, so the decrement wraps to the last slot.
    assign rdIdx   = depthQ[PTR_W-1:0] - PTR_W'(1);

    always_comb begin
        doWrite   = 1'b0;
        wrSel     = wrIdx;
        depthNext = depthQ;
        setOvf    = 1'b0;
        setUnf    = 1'b0;
        unique case ({pushEff, popEff})
            2'b10: begin
                if (isFull) begin
                    setOvf = 1'b1;
                end else begin
                    doWrite   = 1'b1;
                    depthNext = depthQ + ONE;
                end
            end
            2'b01: begin
                if (isEmpty) begin
                    setUnf = 1'b1;
                end else begin
                    depthNext = depthQ - ONE;
                end
            end
            2'b11: begin
                // RET+CALL together replaces the top; on an empty stack the pop half is void.
                doWrite = 1'b1;
                if (isEmpty) begin
                    setUnf    = 1'b1;
                    depthNext = ONE;
                end else begin
                    wrSel = rdIdx;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            depthQ     <= '0;
            overflowQ  <= 1'b0;
            underflowQ <= 1'b0;
        end else begin
            depthQ     <= depthNext;
            overflowQ  <= overflowQ | setOvf;
            underflowQ <= underflowQ | setUnf;
        end
    end

    // Entries are never cleared; Depth alone decides what is live.
    always_ff @(posedge clk) begin
        if (doWrite && !rst) begin
            mem[wrSel] <= bus.ReturnAddr;
        end
    end

    assign bus.TopAddr   = isEmpty ? '0 : mem[rdIdx];
    assign bus.Depth     = depthQ;
    assign bus.Empty     = isEmpty;
    assign bus.Full      = isFull;
    assign bus.Overflow  = overflowQ;
    assign bus.Underflow = underflowQ;
endmodule

// File: tb/tb_call_stack.sv
// Directed bench for call_stack: each driven cycle queues the expected
// post-edge state, and a negedge monitor pops and compares it.
module tb_call_stack;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 16;
    localparam int PTR_W  = 4;
    localparam int W      = 25;

    logic clk = 1'b0;
    logic rst = 1'b1;

    call_stack_if #(.ADDR_W(ADDR_W), .PTR_W(PTR_W)) bus ();

    call_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: {depth[24:20], top[19:4], empty, full, ovf, unf}
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string nm, input string fld,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h at %0t", nm, fld, act, exp, $time);
        end
    endtask

    // Monitor
    initial begin
        logic [W-1:0] e;
        string        nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                chk(nm, "Depth",     32'(bus.Depth),     32'(e[24:20]));
                chk(nm, "TopAddr",   32'(bus.TopAddr),   32'(e[19:4]));
                chk(nm, "Empty",     32'(bus.Empty),     32'(e[3]));
                chk(nm, "Full",      32'(bus.Full),      32'(e[2]));
                chk(nm, "Overflow",  32'(bus.Overflow),  32'(e[1]));
                chk(nm, "Underflow", 32'(bus.Underflow), 32'(e[0]));
            end
        end
    end

    // Driver: apply one cycle of inputs, queue the state expected after the edge.
    task automatic step(input logic p, input logic po, input logic st, input logic r,
                        input logic [15:0] ra, input logic [4:0] eDepth,
                        input logic [15:0] eTop, input logic eOvf, input logic eUnf,
                        input string nm);
        logic eEmpty;
        logic eFull;
        bus.StackPush  = p;
        bus.StackPop   = po;
        bus.Stall      = st;
        bus.ReturnAddr = ra;
        rst            = r;
        eEmpty = (eDepth == 5'd0);
        eFull  = (eDepth == 5'd16);
        @(posedge clk);
        exp_q.push_back({eDepth, eTop, eEmpty, eFull, eOvf, eUnf});
        name_q.push_back(nm);
        #1;
    endtask

    initial begin
        int waitCycles;
        bus.StackPush  = 1'b0;
        bus.StackPop   = 1'b0;
        bus.Stall      = 1'b0;
        bus.ReturnAddr = '0;
        @(posedge clk);
        #1;

        // Reset then idle
        step(0, 0, 0, 1, 16'h0000, 5'd0, 16'h0000, 0, 0, "reset0");
        step(0, 0, 0, 1, 16'h0000, 5'd0, 16'h0000, 0, 0, "reset1");
        step(0, 0, 0, 0, 16'h0000, 5'd0, 16'h0000, 0, 0, "idle");

        // Basic push/pop
        step(1, 0, 0, 0, 16'h0010, 5'd1, 16'h0010, 0, 0, "push10");
        step(1, 0, 0, 0, 16'h0020, 5'd2, 16'h0020, 0, 0, "push20");
        step(0, 1, 0, 0, 16'h0000, 5'd1, 16'h0010, 0, 0, "pop1");
        step(0, 1, 0, 0, 16'h0000, 5'd0, 16'h0000, 0, 0, "pop2");

        // Fill to full, then overflow
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0, 0, 16'h0100 + 16'(i), 5'(i + 1), 16'h0100 + 16'(i), 0, 0, "fill");
        end
        step(1, 0, 0, 0, 16'hBEEF, 5'd16, 16'h010F, 1, 0, "overflow");
        step(1, 1, 0, 0, 16'h0555, 5'd16, 16'h0555, 1, 0, "replace_full");
        step(0, 1, 0, 0, 16'h0000, 5'd15, 16'h010E, 1, 0, "pop_full");
        step(0, 0, 0, 1, 16'h0000, 5'd0, 16'h0000, 0, 0, "reset_ovf");

        // Underflow, then recovery
        step(0, 1, 0, 0, 16'h0000, 5'd0, 16'h0000, 0, 1, "underflow");
        step(1, 0, 0, 0, 16'h0042, 5'd1, 16'h0042, 0, 1, "push_after_unf");
        step(0, 0, 0, 1, 16'h0000, 5'd0, 16'h0000, 0, 0, "reset_unf");

        // Simultaneous push/pop at depth 3
        step(1, 0, 0, 0, 16'h0001, 5'd1, 16'h0001, 0, 0, "push1");
        step(1, 0, 0, 0, 16'h0002, 5'd2, 16'h0002, 0, 0, "push2");
        step(1, 0, 0, 0, 16'h0003, 5'd3, 16'h0003, 0, 0, "push3");
        step(1, 1, 0, 0, 16'h0077, 5'd3, 16'h0077, 0, 0, "replace");
        step(0, 1, 0, 0, 16'h0000, 5'd2, 16'h0002, 0, 0, "pop_e1");
        step(0, 1, 0, 0, 16'h0000, 5'd1, 16'h0001, 0, 0, "pop_e0");
        step(0, 1, 0, 0, 16'h0000, 5'd0, 16'h0000, 0, 0, "pop_last");

        // Push+pop on an empty stack
        step(1, 1, 0, 0, 16'h0099, 5'd1, 16'h0099, 0, 1, "pushpop_empty");

        // Stall holds state
        step(1, 0, 1, 0, 16'h1234, 5'd1, 16'h0099, 0, 1, "stall_push");
        step(1, 1, 1, 0, 16'h5678, 5'd1, 16'h0099, 0, 1, "stall_both");
        step(0, 1, 1, 0, 16'h0000, 5'd1, 16'h0099, 0, 1, "stall_pop");

        // Reset wins over a push at depth 5
        step(1, 0, 0, 0, 16'h00A0, 5'd2, 16'h00A0, 0, 1, "pushA0");
        step(1, 0, 0, 0, 16'h00A1, 5'd3, 16'h00A1, 0, 1, "pushA1");
        step(1, 0, 0, 0, 16'h00A2, 5'd4, 16'h00A2, 0, 1, "pushA2");
        step(1, 0, 0, 0, 16'h00A3, 5'd5, 16'h00A3, 0, 1, "pushA3");
        step(1, 0, 0, 1, 16'h00A4, 5'd0, 16'h0000, 0, 0, "reset_push");
        step(1, 0, 0, 0, 16'h0011, 5'd1, 16'h0011, 0, 0, "push_after_rst");
        step(0, 0, 0, 0, 16'h0000, 5'd1, 16'h0011, 0, 0, "final_idle");

        waitCycles = 0;
        while (exp_q.size() > 0 && waitCycles < 10) begin
            @(posedge clk);
            waitCycles++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
